// File: rtl/dz_brg_pkg.sv
// rtl/dz_brg_pkg.sv - DZ11 speed codes and phase-increment helpers
package dz_brg_pkg;

  localparam logic [3:0] BR50    = 4'd0;
  localparam logic [3:0] BR75    = 4'd1;
  localparam logic [3:0] BR110   = 4'd2;
  localparam logic [3:0] BR134   = 4'd3;
  localparam logic [3:0] BR150   = 4'd4;
  localparam logic [3:0] BR300   = 4'd5;
  localparam logic [3:0] BR600   = 4'd6;
  localparam logic [3:0] BR1200  = 4'd7;
  localparam logic [3:0] BR1800  = 4'd8;
  localparam logic [3:0] BR2000  = 4'd9;
  localparam logic [3:0] BR2400  = 4'd10;
  localparam logic [3:0] BR3600  = 4'd11;
  localparam logic [3:0] BR4800  = 4'd12;
  localparam logic [3:0] BR7200  = 4'd13;
  localparam logic [3:0] BR9600  = 4'd14;
  localparam logic [3:0] BR19200 = 4'd15;

  // Doubled baud keeps 134.5 baud exact in integer math.
  function automatic logic [15:0] brg_b2(input logic [3:0] code);
    case (code)
      BR50:    brg_b2 = 16'd100;
      BR75:    brg_b2 = 16'd150;
      BR110:   brg_b2 = 16'd220;
      BR134:   brg_b2 = 16'd269;
      BR150:   brg_b2 = 16'd300;
      BR300:   brg_b2 = 16'd600;
      BR600:   brg_b2 = 16'd1200;
      BR1200:  brg_b2 = 16'd2400;
      BR1800:  brg_b2 = 16'd3600;
      BR2000:  brg_b2 = 16'd4000;
      BR2400:  brg_b2 = 16'd4800;
      BR3600:  brg_b2 = 16'd7200;
      BR4800:  brg_b2 = 16'd9600;
      BR7200:  brg_b2 = 16'd14400;
      BR9600:  brg_b2 = 16'd19200;
      default: brg_b2 = 16'd38400;
    endcase
  endfunction

  // Round-half-up of b2*clkdiv*2^accw / (2*clkfrq).
  function automatic logic [63:0] brg_inc(input logic [3:0] code,
                                          input int unsigned clkfrq,
                                          input int unsigned clkdiv,
                                          input int unsigned accw);
    logic [63:0] num;
    num = ({48'd0, brg_b2(code)} * 64'(clkdiv)) << accw;
    brg_inc = (num + 64'(clkfrq)) / (64'(clkfrq) << 1);
  endfunction

endpackage

// File: rtl/dz_brg_chan.sv
// rtl/dz_brg_chan.sv - one channel: phase accumulator, speed-change detect, pulse register
module dz_brg_chan
  import dz_brg_pkg::*;
#(
  parameter int unsigned CLKFRQ = 50000000,
  parameter int unsigned CLKDIV = 16,
  parameter int unsigned ACCW   = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sel,
  input  logic       en,
  output logic       clken
);

  logic [ACCW-1:0] inc_tbl [16];

  for (genvar c = 0; c < 16; c++) begin : g_inc
    localparam logic [63:0] INC64 = brg_inc(4'(c), CLKFRQ, CLKDIV, ACCW);
    assign inc_tbl[c] = INC64[ACCW-1:0];
  end

  logic [ACCW-1:0] acc;
  logic [3:0]      selq;
  logic [ACCW:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, inc_tbl[selq]};

  // selq tracks sel even while disabled so re-enable starts at the new code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      selq  <= '0;
      clken <= 1'b0;
    end else begin
      selq <= sel;
      if (!en || (sel != selq)) begin
        acc   <= '0;
        clken <= 1'b0;
      end else begin
        acc   <= sum[ACCW-1:0];
        clken <= sum[ACCW];
      end
    end
  end

endmodule

// File: rtl/dz_brg.sv
// rtl/dz_brg.sv - multi-channel fractional 16x baud clock-enable generator
module dz_brg
  import dz_brg_pkg::*;
#(
  parameter int unsigned CLKFRQ = 50000000,
  parameter int unsigned CLKDIV = 16,
  parameter int unsigned NCH    = 8,
  parameter int unsigned ACCW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NCH-1:0]  brgSEL,
  input  logic [NCH-1:0]    brgEN,
  output logic [NCH-1:0]    brgCLKEN
);

  if (CLKFRQ < 2 * CLKDIV * 19200) begin : g_bad_clk
    $error("dz_brg: CLKFRQ too low for back-to-back-free 19200 baud");
  end
  if (ACCW > 40 || ACCW < 24) begin : g_bad_accw
    $error("dz_brg: ACCW must be 24..40");
  end
  if (NCH < 1 || NCH > 16) begin : g_bad_nch
    $error("dz_brg: NCH must be 1..16");
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    dz_brg_chan #(
      .CLKFRQ(CLKFRQ),
      .CLKDIV(CLKDIV),
      .ACCW  (ACCW)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .sel  (brgSEL[4*i +: 4]),
      .en   (brgEN[i]),
      .clken(brgCLKEN[i])
    );
  end

endmodule

// File: tb/tb_dz_brg.sv
// tb/tb_dz_brg.sv - randomized and directed checks of dz_brg against a closed-form model
module tb_dz_brg;

  localparam int NCH  = 8;
  localparam int ACCW = 32;
  localparam longint unsigned B2T [16] = '{100, 150, 220, 269, 300, 600, 1200, 2400,
                                           3600, 4000, 4800, 7200, 9600, 14400, 19200, 38400};

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4*NCH-1:0] sel = '0;
  logic [NCH-1:0]   en  = '0;
  logic [NCH-1:0]   clken;

  int checks = 0;
  int errors = 0;

  longint unsigned mk [NCH];
  logic [3:0]      mq [NCH];
  logic [NCH-1:0]  mexp = '0;

  dz_brg #(
    .CLKFRQ(50000000),
    .CLKDIV(16),
    .NCH   (NCH),
    .ACCW  (ACCW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .brgSEL  (sel),
    .brgEN   (en),
    .brgCLKEN(clken)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint unsigned ref_inc(input int code);
    longint unsigned one;
    one = 64'd1 << ACCW;
    return (B2T[code] * 16 * one + 64'd50000000) / 64'd100000000;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      mk[ch] = 0;
      mq[ch] = 4'd0;
    end
    mexp = '0;
  endtask

  // Pulse after the k-th counted edge iff floor(k*INC/2^ACCW) steps up.
  task automatic tick();
    logic [4*NCH-1:0] s;
    logic [NCH-1:0]   e;
    logic             r;
    longint unsigned  inc;
    s = sel;
    e = en;
    r = rst;
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (!e[ch] || (s[4*ch +: 4] != mq[ch])) begin
          mk[ch]   = 0;
          mexp[ch] = 1'b0;
        end else begin
          mk[ch]++;
          inc = ref_inc(int'(mq[ch]));
          mexp[ch] = ((mk[ch] * inc) >> ACCW) != (((mk[ch] - 1) * inc) >> ACCW);
        end
        mq[ch] = s[4*ch +: 4];
      end
    end
    check("clken", 64'(clken), 64'(mexp));
  endtask

  task automatic run_until(input int ch, input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!clken[ch] && n < limit);
  endtask

  int n;
  int total;
  int cnt [NCH];
  int codes [NCH];
  longint unsigned expc;

  initial begin
    model_reset();
    repeat (3) tick();
    rst = 1'b0;

    // 9600 baud first pulse and intervals
    sel[3:0] = 4'd14;
    tick();
    en[0] = 1'b1;
    run_until(0, 400, n);
    check("first14", 64'(n), 64'd326);
    for (int i = 0; i < 8; i++) begin
      run_until(0, 400, n);
      check("ivl14", 64'(n == 325 || n == 326), 64'd1);
    end

    // speed change mid-period
    repeat (50) tick();
    sel[3:0] = 4'd15;
    tick();
    check("chg_edge", 64'(clken[0]), 64'd0);
    run_until(0, 300, n);
    check("chg163", 64'(n), 64'd163);
    for (int i = 0; i < 8; i++) begin
      run_until(0, 300, n);
      check("ivl19200", 64'(n == 162 || n == 163), 64'd1);
    end

    // disable and change on the same edge
    repeat (40) tick();
    en[0]    = 1'b0;
    sel[3:0] = 4'd14;
    tick();
    check("collide", 64'(clken[0]), 64'd0);
    repeat (3) tick();
    en[0] = 1'b1;
    run_until(0, 400, n);
    check("reen14", 64'(n), 64'd326);

    // 134.5 baud
    en[0]    = 1'b0;
    sel[3:0] = 4'd3;
    tick();
    en[0] = 1'b1;
    run_until(0, 24000, n);
    check("first134", 64'(n), 64'd23235);

    // all channels at once, independent rates
    codes = '{0, 3, 7, 10, 12, 13, 14, 15};
    en = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      sel[4*ch +: 4] = 4'(codes[ch]);
      cnt[ch] = 0;
    end
    tick();
    en = '1;
    repeat (25000) begin
      tick();
      for (int ch = 0; ch < NCH; ch++) cnt[ch] += int'(clken[ch]);
    end
    for (int ch = 0; ch < NCH; ch++) begin
      expc = (64'd25000 * ref_inc(codes[ch])) >> ACCW;
      check($sformatf("count_ch%0d", ch), 64'(cnt[ch]), expc);
    end

    // random enables and speed codes
    repeat (15000) begin
      for (int ch = 0; ch < NCH; ch++) begin
        case ($urandom_range(0, 299))
          0: en[ch] = ~en[ch];
          1: sel[4*ch +: 4] = 4'($urandom_range(0, 15));
          default: ;
        endcase
      end
      tick();
    end

    // async reset while a pulse is high
    en = '1;
    for (int ch = 0; ch < NCH; ch++) sel[4*ch +: 4] = 4'd15;
    tick();
    run_until(0, 400, n);
    check("pulse_before_rst", 64'(clken[0]), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 64'(clken), 64'd0);
    model_reset();
    en = '0;
    tick();
    rst   = 1'b0;
    total = 0;
    repeat (1000) begin
      tick();
      total += $countones(clken);
    end
    check("idle_pulses", 64'(total), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
